// File: rtl/bank_wr_ctrl_pkg.sv
// Shared constants and types for the cache-way bank write controller.
package bank_wr_ctrl_pkg;

    localparam int BANK_NUM     = 4;   // banks per line, also beats per refill
    localparam int RAM_NUM      = 4;   // byte RAMs per bank
    localparam int DATA_WIDTH   = 32;  // word width
    localparam int CACHE_RAM_AW = 10;  // bank address width
    localparam int STARVE_LIM   = 8;   // lost arbitrations before refill is forced through

    typedef enum logic {
        IDLE   = 1'b0,
        REFILL = 1'b1
    } state_t;

    // Bits needed to count from 0 up to and including lim.
    function automatic int cnt_width(input int lim);
        return (lim < 1) ? 1 : $clog2(lim + 1);
    endfunction

endpackage

// File: rtl/bank_wr_arb.sv
// IDLE-state arbitration between store hits and line refills.
// Stores normally win; a refill that has lost STARVE_LIM times in a row takes priority.
module bank_wr_arb
    import bank_wr_ctrl_pkg::*;
#(
    parameter int STARVE_LIM = bank_wr_ctrl_pkg::STARVE_LIM
) (
    input  logic clk,
    input  logic rst_n,
    input  logic is_idle,
    input  logic refill_req,
    input  logic st_req,
    output logic st_gnt,
    output logic refill_gnt
);

    localparam int SW = cnt_width(STARVE_LIM);

    logic [SW-1:0] starve_cnt_reg;
    logic          starved;

    assign starved    = (starve_cnt_reg == SW'(STARVE_LIM));
    assign refill_gnt = is_idle & refill_req & (~st_req | starved);
    assign st_gnt     = is_idle & st_req & ~refill_gnt;

    // Count consecutive IDLE cycles where a pending refill lost to a store; saturate at the limit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            starve_cnt_reg <= '0;
        end else if (refill_gnt) begin
            starve_cnt_reg <= '0;
        end else if (is_idle && refill_req && !starved) begin
            starve_cnt_reg <= starve_cnt_reg + 1'b1;
        end
    end

endmodule

// File: rtl/bank_wr_ctrl.sv
// Write-port controller for one cache way's data banks.
// Refill bursts write one bank per accepted beat; store hits write selected bytes of one bank.
// All RAM-facing outputs are registered, so a write lands one cycle after its handshake.
module bank_wr_ctrl
    import bank_wr_ctrl_pkg::*;
#(
    parameter int BANK_NUM   = bank_wr_ctrl_pkg::BANK_NUM,
    parameter int RAM_NUM    = bank_wr_ctrl_pkg::RAM_NUM,
    parameter int DATA_WIDTH = bank_wr_ctrl_pkg::DATA_WIDTH,
    parameter int AW         = bank_wr_ctrl_pkg::CACHE_RAM_AW,
    parameter int STARVE_LIM = bank_wr_ctrl_pkg::STARVE_LIM
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          refill_req_i,
    input  logic [AW-1:0]                 refill_addr_i,
    input  logic                          refill_valid_i,
    input  logic [DATA_WIDTH-1:0]         refill_data_i,
    output logic                          refill_ready_o,
    output logic                          refill_done_o,
    input  logic                          st_req_i,
    input  logic [AW-1:0]                 st_addr_i,
    input  logic [$clog2(BANK_NUM)-1:0]   st_bank_i,
    input  logic [RAM_NUM-1:0]            st_strb_i,
    input  logic [DATA_WIDTH-1:0]         st_data_i,
    output logic                          st_gnt_o,
    output logic [BANK_NUM*RAM_NUM-1:0]   bank_wr_en_o,
    output logic [AW-1:0]                 bank_wr_addr_o,
    output logic [DATA_WIDTH-1:0]         bank_wr_data_o
);

    localparam int BW = $clog2(BANK_NUM);

    state_t                        state_reg;
    logic [BW-1:0]                 beat_cnt_reg;
    logic [AW-1:0]                 line_addr_reg;
    logic                          refill_gnt;
    logic [BANK_NUM*RAM_NUM-1:0]   store_mask;
    logic [BANK_NUM*RAM_NUM-1:0]   refill_mask;
    logic                          last_beat;

    bank_wr_arb #(
        .STARVE_LIM (STARVE_LIM)
    ) u_arb (
        .clk        (clk),
        .rst_n      (rst_n),
        .is_idle    (state_reg == IDLE),
        .refill_req (refill_req_i),
        .st_req     (st_req_i),
        .st_gnt     (st_gnt_o),
        .refill_gnt (refill_gnt)
    );

    // Per-bank enable slices: the store puts its strobes on the addressed bank,
    // a refill beat enables every byte of the bank selected by the beat counter.
    for (genvar gi = 0; gi < BANK_NUM; gi++) begin : g_bank_mask
        assign store_mask[gi*RAM_NUM +: RAM_NUM]  = (st_bank_i == BW'(gi)) ? st_strb_i : '0;
        assign refill_mask[gi*RAM_NUM +: RAM_NUM] = {RAM_NUM{beat_cnt_reg == BW'(gi)}};
    end

    assign last_beat      = (beat_cnt_reg == BW'(BANK_NUM - 1));
    assign refill_ready_o = (state_reg == REFILL);

    // Control FSM with registered write port; address/data hold on cycles without a write.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg      <= IDLE;
            beat_cnt_reg   <= '0;
            line_addr_reg  <= '0;
            bank_wr_en_o   <= '0;
            bank_wr_addr_o <= '0;
            bank_wr_data_o <= '0;
            refill_done_o  <= 1'b0;
        end else begin
            bank_wr_en_o  <= '0;
            refill_done_o <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (st_gnt_o) begin
                        bank_wr_en_o   <= store_mask;
                        bank_wr_addr_o <= st_addr_i;
                        bank_wr_data_o <= st_data_i;
                    end
                    if (refill_gnt) begin
                        line_addr_reg <= refill_addr_i;
                        beat_cnt_reg  <= '0;
                        state_reg     <= REFILL;
                    end
                end
                REFILL: begin
                    if (refill_valid_i) begin
                        bank_wr_en_o   <= refill_mask;
                        bank_wr_addr_o <= line_addr_reg;
                        bank_wr_data_o <= refill_data_i;
                        beat_cnt_reg   <= beat_cnt_reg + 1'b1;
                        if (last_beat) begin
                            state_reg     <= IDLE;
                            refill_done_o <= 1'b1;
                        end
                    end
                end
            endcase
        end
    end

    // The refill unit must keep its request up for the whole burst.
    refill_req_held: assert property (@(posedge clk) disable iff (!rst_n)
        (state_reg == REFILL) |-> refill_req_i);

endmodule

// File: tb/tb_bank_wr_ctrl.sv
// Self-checking bench for bank_wr_ctrl: directed scenarios plus randomized traffic
// compared against a cycle-level behavioural model of the write port.
module tb_bank_wr_ctrl;
    import bank_wr_ctrl_pkg::*;

    localparam int BN = BANK_NUM;
    localparam int RN = RAM_NUM;
    localparam int SL = STARVE_LIM;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        refill_req_i;
    logic [9:0]  refill_addr_i;
    logic        refill_valid_i;
    logic [31:0] refill_data_i;
    logic        refill_ready_o;
    logic        refill_done_o;
    logic        st_req_i;
    logic [9:0]  st_addr_i;
    logic [1:0]  st_bank_i;
    logic [3:0]  st_strb_i;
    logic [31:0] st_data_i;
    logic        st_gnt_o;
    logic [15:0] bank_wr_en_o;
    logic [9:0]  bank_wr_addr_o;
    logic [31:0] bank_wr_data_o;

    bank_wr_ctrl dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .refill_req_i   (refill_req_i),
        .refill_addr_i  (refill_addr_i),
        .refill_valid_i (refill_valid_i),
        .refill_data_i  (refill_data_i),
        .refill_ready_o (refill_ready_o),
        .refill_done_o  (refill_done_o),
        .st_req_i       (st_req_i),
        .st_addr_i      (st_addr_i),
        .st_bank_i      (st_bank_i),
        .st_strb_i      (st_strb_i),
        .st_data_i      (st_data_i),
        .st_gnt_o       (st_gnt_o),
        .bank_wr_en_o   (bank_wr_en_o),
        .bank_wr_addr_o (bank_wr_addr_o),
        .bank_wr_data_o (bank_wr_data_o)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    endtask

    // Behavioural model state
    bit          m_refilling;
    int          m_beats;
    int          m_starve;
    logic [9:0]  m_line;
    logic [15:0] exp_en;
    logic [9:0]  exp_addr;
    logic [31:0] exp_data;
    bit          exp_done;
    bit          last_sgnt;
    bit          last_rgnt;
    bit          last_dut_sgnt;

    task automatic model_reset();
        m_refilling = 0;
        m_beats     = 0;
        m_starve    = 0;
        m_line      = '0;
        exp_en      = '0;
        exp_addr    = '0;
        exp_data    = '0;
        exp_done    = 0;
        last_sgnt   = 0;
        last_rgnt   = 0;
    endtask

    task automatic drive_idle();
        refill_req_i   = 0;
        refill_addr_i  = '0;
        refill_valid_i = 0;
        refill_data_i  = '0;
        st_req_i       = 0;
        st_addr_i      = '0;
        st_bank_i      = '0;
        st_strb_i      = '0;
        st_data_i      = '0;
    endtask

    // Called just after a negedge with inputs applied: checks the handshake outputs,
    // advances the model over the next posedge and checks the registered write port.
    task automatic step();
        bit          sgnt;
        bit          rgnt;
        logic [15:0] ones;
        #1;
        rgnt = !m_refilling && refill_req_i && (!st_req_i || (m_starve >= SL));
        sgnt = !m_refilling && st_req_i && !rgnt;
        last_dut_sgnt = st_gnt_o;
        check("st_gnt", 64'(st_gnt_o), 64'(sgnt));
        check("refill_ready", 64'(refill_ready_o), 64'(m_refilling));
        exp_en   = '0;
        exp_done = 0;
        if (m_refilling) begin
            if (refill_valid_i) begin
                ones     = 16'({RN{1'b1}});
                exp_en   = ones << (m_beats * RN);
                exp_addr = m_line;
                exp_data = refill_data_i;
                m_beats++;
                if (m_beats == BN) begin
                    m_refilling = 0;
                    m_beats     = 0;
                    exp_done    = 1;
                    $display("refill done  line=0x%03h", m_line);
                end
            end
        end else begin
            if (sgnt) begin
                exp_en   = {12'b0, st_strb_i} << (int'(st_bank_i) * RN);
                exp_addr = st_addr_i;
                exp_data = st_data_i;
                $display("store grant  bank=%0d strb=%b addr=0x%03h data=0x%08h",
                         st_bank_i, st_strb_i, st_addr_i, st_data_i);
            end
            if (rgnt) begin
                m_refilling = 1;
                m_line      = refill_addr_i;
                m_beats     = 0;
                m_starve    = 0;
                $display("refill grant line=0x%03h", refill_addr_i);
            end else if (refill_req_i) begin
                m_starve = (m_starve < SL) ? m_starve + 1 : SL;
            end
        end
        last_sgnt = sgnt;
        last_rgnt = rgnt;
        @(negedge clk);
        check("wr_en", 64'(bank_wr_en_o), 64'(exp_en));
        check("wr_addr", 64'(bank_wr_addr_o), 64'(exp_addr));
        check("wr_data", 64'(bank_wr_data_o), 64'(exp_data));
        check("refill_done", 64'(refill_done_o), 64'(exp_done));
    endtask

    // Asynchronous reset applied at a negedge; everything must clear immediately.
    task automatic do_reset();
        rst_n = 0;
        drive_idle();
        #1;
        model_reset();
        check("rst_wr_en", 64'(bank_wr_en_o), 64'h0);
        check("rst_wr_addr", 64'(bank_wr_addr_o), 64'h0);
        check("rst_wr_data", 64'(bank_wr_data_o), 64'h0);
        check("rst_done", 64'(refill_done_o), 64'h0);
        check("rst_ready", 64'(refill_ready_o), 64'h0);
        check("rst_gnt", 64'(st_gnt_o), 64'h0);
        repeat (2) @(negedge clk);
        rst_n = 1;
    endtask

    task automatic set_store(input logic [1:0] b, input logic [3:0] s,
                             input logic [9:0] a, input logic [31:0] d);
        st_req_i  = 1;
        st_bank_i = b;
        st_strb_i = s;
        st_addr_i = a;
        st_data_i = d;
    endtask

    initial begin
        int wins;
        rst_n = 0;
        drive_idle();
        model_reset();
        @(negedge clk);
        do_reset();

        // 1: idle after reset, nothing written
        repeat (3) step();

        // 2: single store hit
        set_store(2'd2, 4'b0101, 10'h03C, 32'hA5A5_A5A5);
        step();
        check("t2_en", 64'(bank_wr_en_o), 64'h0500);
        check("t2_addr", 64'(bank_wr_addr_o), 64'h03C);
        check("t2_data", 64'(bank_wr_data_o), 64'hA5A5_A5A5);
        st_req_i = 0;

        // 3: refill at 0x100 with a one-cycle valid gap after beat 1
        refill_req_i  = 1;
        refill_addr_i = 10'h100;
        step();
        for (int k = 0; k < BN; k++) begin
            refill_valid_i = 1;
            refill_data_i  = 32'h11 * (k + 1);
            step();
            check("t3_en", 64'(bank_wr_en_o), 64'(16'h000F << (4 * k)));
            check("t3_addr", 64'(bank_wr_addr_o), 64'h100);
            if (k == 1) begin
                refill_valid_i = 0;
                step();
                check("t3_gap_en", 64'(bank_wr_en_o), 64'h0);
            end
        end
        check("t3_done", 64'(refill_done_o), 64'h1);
        refill_req_i   = 0;
        refill_valid_i = 0;
        step();
        check("t3_idle_ready", 64'(refill_ready_o), 64'h0);

        // 4: store arriving during a refill waits, then is granted on the first IDLE cycle
        refill_req_i  = 1;
        refill_addr_i = 10'h200;
        step();
        set_store(2'd1, 4'hF, 10'h044, 32'hDEAD_BEEF);
        for (int k = 0; k < BN; k++) begin
            refill_valid_i = 1;
            refill_data_i  = $urandom;
            step();
            check("t4_held", 64'(last_dut_sgnt), 64'h0);
        end
        refill_req_i   = 0;
        refill_valid_i = 0;
        step();
        check("t4_gnt", 64'(last_dut_sgnt), 64'h1);
        check("t4_en", 64'(bank_wr_en_o), 64'h00F0);
        st_req_i = 0;

        // 5: starvation, stores win STARVE_LIM times then the refill is granted
        refill_req_i  = 1;
        refill_addr_i = 10'h2C0;
        set_store(2'd3, 4'b0011, 10'h010, 32'h1234_5678);
        wins = 0;
        for (int c = 0; c < SL + 4; c++) begin
            step();
            if (last_dut_sgnt) wins++;
            if (!last_dut_sgnt) break;
            set_store(2'($urandom), 4'($urandom), 10'($urandom), $urandom);
        end
        check("t5_store_wins", 64'(wins), 64'(SL));
        check("t5_ready", 64'(refill_ready_o), 64'h1);
        for (int k = 0; k < BN; k++) begin
            refill_valid_i = 1;
            refill_data_i  = $urandom;
            step();
        end
        refill_req_i   = 0;
        refill_valid_i = 0;
        step();
        st_req_i = 0;

        // 6: reset in the middle of a refill, then a clean refill
        refill_req_i  = 1;
        refill_addr_i = 10'h300;
        step();
        refill_valid_i = 1;
        refill_data_i  = 32'hCAFE_0000;
        step();
        refill_data_i  = 32'hCAFE_0001;
        step();
        do_reset();
        step();
        refill_req_i  = 1;
        refill_addr_i = 10'h340;
        step();
        for (int k = 0; k < BN; k++) begin
            refill_valid_i = 1;
            refill_data_i  = $urandom;
            step();
        end
        check("t6_done", 64'(refill_done_o), 64'h1);
        refill_req_i   = 0;
        refill_valid_i = 0;

        // Randomized traffic obeying the request/hold protocols
        for (int c = 0; c < 600; c++) begin
            if (last_sgnt || !st_req_i) begin
                st_req_i  = ($urandom_range(0, 2) == 0);
                st_bank_i = 2'($urandom);
                st_strb_i = 4'($urandom);
                st_addr_i = 10'($urandom);
                st_data_i = $urandom;
            end
            if (exp_done) begin
                refill_req_i = 0;
            end else if (!refill_req_i && !m_refilling) begin
                refill_req_i  = ($urandom_range(0, 7) == 0);
                refill_addr_i = 10'($urandom);
            end
            refill_valid_i = 1'($urandom);
            refill_data_i  = $urandom;
            step();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
